msrv32_pipe_ctrl: RTL and testbench
===================================

Name: msrv32_pipe_ctrl

Overview:
Hazard and sequencing controller for the MSRV32 3-stage pipeline.
- Drives the stall and flush controls of the stage-1 pipeline register (reg_block_1), the stage-2 pipeline register (msrv32_reg_block_2) and the PC register.
- Handles load-use hazards, data-memory wait states with timeout, branch flushes, and trap-entry drain.
- Sits beside the decode stage. Observes stage-2 source addresses and the stage-3 outputs of msrv32_reg_block_2.

Parameters:
- MEM_TIMEOUT, 16: dmem wait cycles before bus_error_out fires; legal range 2..255.
- TRAP_FLUSH_CYC, 2: cycles both pipeline registers are flushed on trap entry; legal range 1..7.
- STALL_CNT_W, 32: width of the saturating stall-cycle counter.

Ports:
- clk_in  input  1  pipeline clock, rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- rs1_addr_in  input  5  stage-2 rs1 address.
- rs2_addr_in  input  5  stage-2 rs2 address.
- rs_used_in  input  2  bit0 = rs1 read, bit1 = rs2 read by the stage-2 instruction.
- rd_addr_reg_in  input  5  stage-3 rd (rd_addr_reg_out of reg_block_2).
- rf_wr_en_reg_in  input  1  stage-3 register-file write enable.
- load_reg_in  input  1  stage-3 instruction is a load.
- mem_req_reg_in  input  1  stage-3 issues a data-memory access.
- dmem_ready_in  input  1  data memory completes the access this cycle.
- branch_taken_in  input  1  stage-2 branch/jump resolved taken.
- trap_taken_in  input  1  trap/interrupt accepted (single-cycle pulse).
- pc_stall_out  output  1  hold the PC.
- reg1_stall_out  output  1  hold reg_block_1.
- reg2_stall_out  output  1  hold reg_block_2.
- reg1_flush_out  output  1  load a bubble into reg_block_1.
- reg2_flush_out  output  1  load a bubble into reg_block_2.
- pc_src_trap_out  output  1  select the trap vector for the next PC.
- bus_error_out  output  1  one-cycle pulse on dmem timeout.
- stall_cycles_out  output  STALL_CNT_W  saturating count of pc_stall_out cycles.

Behaviour:
- Clock/reset: single clock clk_in. reset_in is asynchronous and active-high.
- While reset_in = 1:
  - state = RUN; wait_cnt, drain_cnt, trap_pending and stall_cycles_out = 0.
  - reg1_flush_out = reg2_flush_out = 1; all other outputs 0.
- Stall/flush outputs are combinational from state and inputs, with zero-cycle latency. bus_error_out and stall_cycles_out are registered.
- Load-use hazard: luh = load_reg_in & rf_wr_en_reg_in & (rd_addr_reg_in != 0) & ((rs_used_in[0] & rs1_addr_in == rd_addr_reg_in) | (rs_used_in[1] & rs2_addr_in == rd_addr_reg_in)).
- States:
  - RUN, priority highest first:
    - (a) mem_req_reg_in & !dmem_ready_in: pc/reg1/reg2 stall = 1, no flush. Go to MEM_WAIT with wait_cnt = 1. A coincident trap_taken_in sets trap_pending.
    - (b) trap_taken_in: pc_src_trap_out = 1, reg1/reg2 flush = 1. Go to TRAP_DRAIN with drain_cnt = 1. If TRAP_FLUSH_CYC = 1, stay in RUN.
    - (c) branch_taken_in: reg1_flush_out = 1 for one cycle. A coincident luh is ignored, because the stage-2 instruction is correct-path and stage 1 is discarded.
    - (d) luh: pc_stall_out = reg1_stall_out = 1 and reg2_flush_out = 1, giving a one-cycle bubble. No state change; the bubble clears load_reg_in on the next cycle.
  - MEM_WAIT: pc/reg1/reg2 stall = 1.
    - On dmem_ready_in: stalls drop in that cycle. Go to TRAP_DRAIN if trap_pending (assert pc_src_trap_out, clear trap_pending), else go to RUN.
    - Else if wait_cnt == MEM_TIMEOUT: bus_error_out pulses the next cycle. pc_src_trap_out = 1 and both flushes = 1. Go to TRAP_DRAIN.
    - Else wait_cnt++.
    - trap_taken_in sets trap_pending. branch_taken_in and luh are ignored.
  - TRAP_DRAIN: reg1/reg2 flush = 1, stalls = 0.
    - drain_cnt++ until drain_cnt == TRAP_FLUSH_CYC, then go to RUN.
    - branch_taken_in, luh and trap_taken_in are ignored.
- stall_cycles_out increments on every cycle pc_stall_out = 1 and saturates at all-ones.
- Reset mid-operation: any state returns to RUN immediately, and pending traps and counters are lost.

Decomposition:
- Package msrv32_pkg holds the state encoding (RUN = 2'd0, MEM_WAIT = 2'd1, TRAP_DRAIN = 2'd2) and the register address width constant (5).
- Sub-module msrv32_hazard_detect: combinational luh compare, instantiated once.

Test Plan:
1. Reset held 3 cycles, then released -> during reset reg1/reg2 flush = 1 and all else 0; after release, stall_cycles_out = 0 and state = RUN.
2. Load-use: load_reg_in = 1, rf_wr_en_reg_in = 1, rd_addr_reg_in = 5, rs1_addr_in = 5, rs_used_in = 01 -> pc/reg1 stall and reg2 flush for exactly 1 cycle; stall_cycles_out = 1. The same stimulus with rd_addr_reg_in = 0 produces no stall.
3. mem_req_reg_in = 1 with dmem_ready_in low for 4 cycles, then high -> all stalls high for 4 cycles and low on the ready cycle; stall_cycles_out = 4; no bus_error_out.
4. dmem_ready_in held low with MEM_TIMEOUT = 16 -> bus_error_out pulses once after 16 wait cycles; pc_src_trap_out = 1; both flushes high for TRAP_FLUSH_CYC = 2 cycles; then RUN.
5. branch_taken_in and luh in the same RUN cycle -> only reg1_flush_out = 1; no stall; stall_cycles_out unchanged.
6. trap_taken_in pulsed during MEM_WAIT, then dmem_ready_in after 3 cycles -> pc_src_trap_out = 1 on the ready cycle, then 2 flush cycles. trap_taken_in during TRAP_DRAIN is ignored. Asserting reset_in mid-MEM_WAIT drops trap_pending.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared constants for the MSRV32 pipeline control slice: FSM state
// encoding and register-address width.
package msrv32_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] MEM_WAIT   = 2'd1;
    localparam logic [1:0] TRAP_DRAIN = 2'd2;

endpackage

// File: rtl/msrv32_hazard_detect.sv
// Load-use hazard compare: the stage-3 load writes a register that the
// stage-2 instruction reads. x0 never creates a hazard.
import msrv32_pkg::*;

module msrv32_hazard_detect (
    input  reg_addr_t  rs1_addr,
    input  reg_addr_t  rs2_addr,
    input  logic [1:0] rs_used,
    input  reg_addr_t  rd_addr,
    input  logic       rf_wr_en,
    input  logic       load,
    output logic       luh
);

    logic rs1_hit;
    logic rs2_hit;

    // Per-source match, qualified by whether the source is actually read.
    always_comb begin
        rs1_hit = rs_used[0] && (rs1_addr == rd_addr);
        rs2_hit = rs_used[1] && (rs2_addr == rd_addr);
        luh     = load && rf_wr_en && (rd_addr != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/msrv32_pipe_ctrl.sv
// Hazard and sequencing controller for the MSRV32 3-stage pipeline.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RUN        | normal flow; resolves dmem stall, trap, branch, load-use
// MEM_WAIT   | stage-3 data access outstanding; whole pipe held
// TRAP_DRAIN | trap entered; both pipeline registers loaded with bubbles
//
// drain_cnt counts flush cycles already spent on the current trap entry,
// so the cycle that redirects the PC and also flushes counts as one.
import msrv32_pkg::*;

module msrv32_pipe_ctrl #(
    parameter int MEM_TIMEOUT    = 16,
    parameter int TRAP_FLUSH_CYC = 2,
    parameter int STALL_CNT_W    = 32
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  reg_addr_t              rs1_addr_in,
    input  reg_addr_t              rs2_addr_in,
    input  logic [1:0]             rs_used_in,
    input  reg_addr_t              rd_addr_reg_in,
    input  logic                   rf_wr_en_reg_in,
    input  logic                   load_reg_in,
    input  logic                   mem_req_reg_in,
    input  logic                   dmem_ready_in,
    input  logic                   branch_taken_in,
    input  logic                   trap_taken_in,
    output logic                   pc_stall_out,
    output logic                   reg1_stall_out,
    output logic                   reg2_stall_out,
    output logic                   reg1_flush_out,
    output logic                   reg2_flush_out,
    output logic                   pc_src_trap_out,
    output logic                   bus_error_out,
    output logic [STALL_CNT_W-1:0] stall_cycles_out
);

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam logic [3:0] FLUSH_VAL   = 4'(TRAP_FLUSH_CYC);
    localparam bit         MULTI_FLUSH = (TRAP_FLUSH_CYC > 1);

    logic [1:0] state,        state_nxt;
    logic [7:0] wait_cnt,     wait_nxt;
    logic [2:0] drain_cnt,    drain_nxt;
    logic       trap_pending, pending_nxt;
    logic       timeout;
    logic       luh;

    msrv32_hazard_detect u_hazard (
        .rs1_addr (rs1_addr_in),
        .rs2_addr (rs2_addr_in),
        .rs_used  (rs_used_in),
        .rd_addr  (rd_addr_reg_in),
        .rf_wr_en (rf_wr_en_reg_in),
        .load     (load_reg_in),
        .luh      (luh)
    );

    // Next-state decode and zero-latency stall/flush controls.
    always_comb begin
        pc_stall_out    = 1'b0;
        reg1_stall_out  = 1'b0;
        reg2_stall_out  = 1'b0;
        reg1_flush_out  = 1'b0;
        reg2_flush_out  = 1'b0;
        pc_src_trap_out = 1'b0;
        timeout         = 1'b0;
        state_nxt       = state;
        wait_nxt        = wait_cnt;
        drain_nxt       = drain_cnt;
        pending_nxt     = trap_pending;

        if (reset_in) begin
            reg1_flush_out = 1'b1;
            reg2_flush_out = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req_reg_in && !dmem_ready_in) begin
                        pc_stall_out   = 1'b1;
                        reg1_stall_out = 1'b1;
                        reg2_stall_out = 1'b1;
                        state_nxt      = MEM_WAIT;
                        wait_nxt       = 8'd1;
                        pending_nxt    = trap_taken_in;
                    end else if (trap_taken_in) begin
                        pc_src_trap_out = 1'b1;
                        reg1_flush_out  = 1'b1;
                        reg2_flush_out  = 1'b1;
                        if (MULTI_FLUSH) begin
                            state_nxt = TRAP_DRAIN;
                            drain_nxt = 3'd1;
                        end
                    end else if (branch_taken_in) begin
                        // stage-2 is correct-path; only stage 1 is wrong-path
                        reg1_flush_out = 1'b1;
                    end else if (luh) begin
                        pc_stall_out   = 1'b1;
                        reg1_stall_out = 1'b1;
                        reg2_flush_out = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready_in) begin
                        // access completes normally; trap takes effect after it
                        pending_nxt = 1'b0;
                        if (trap_pending || trap_taken_in) begin
                            pc_src_trap_out = 1'b1;
                            state_nxt       = TRAP_DRAIN;
                            drain_nxt       = 3'd0;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else if (wait_cnt == TIMEOUT_VAL) begin
                        // stalls released so the PC can load the trap vector
                        timeout         = 1'b1;
                        pc_src_trap_out = 1'b1;
                        reg1_flush_out  = 1'b1;
                        reg2_flush_out  = 1'b1;
                        pending_nxt     = 1'b0;
                        if (MULTI_FLUSH) begin
                            state_nxt = TRAP_DRAIN;
                            drain_nxt = 3'd1;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else begin
                        pc_stall_out   = 1'b1;
                        reg1_stall_out = 1'b1;
                        reg2_stall_out = 1'b1;
                        wait_nxt       = wait_cnt + 8'd1;
                        if (trap_taken_in) begin
                            pending_nxt = 1'b1;
                        end
                    end
                end
                TRAP_DRAIN: begin
                    reg1_flush_out = 1'b1;
                    reg2_flush_out = 1'b1;
                    if (({1'b0, drain_cnt} + 4'd1) >= FLUSH_VAL) begin
                        state_nxt = RUN;
                    end else begin
                        drain_nxt = drain_cnt + 3'd1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // State, counters, registered bus error and saturating stall counter.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state            <= RUN;
            wait_cnt         <= '0;
            drain_cnt        <= '0;
            trap_pending     <= 1'b0;
            bus_error_out    <= 1'b0;
            stall_cycles_out <= '0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_nxt;
            drain_cnt     <= drain_nxt;
            trap_pending  <= pending_nxt;
            bus_error_out <= timeout;
            if (pc_stall_out && (stall_cycles_out != '1)) begin
                stall_cycles_out <= stall_cycles_out + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_msrv32_pipe_ctrl.sv
// Self-checking bench for msrv32_pipe_ctrl: a vector table of per-cycle
// inputs and expected outputs, compared through a scoreboard queue.
import msrv32_pkg::*;

module tb_msrv32_pipe_ctrl;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    reg_addr_t   rs1_addr_in = '0, rs2_addr_in = '0, rd_addr_reg_in = '0;
    logic [1:0]  rs_used_in = '0;
    logic        rf_wr_en_reg_in = 0, load_reg_in = 0, mem_req_reg_in = 0;
    logic        dmem_ready_in = 0, branch_taken_in = 0, trap_taken_in = 0;
    logic        pc_stall_out, reg1_stall_out, reg2_stall_out;
    logic        reg1_flush_out, reg2_flush_out, pc_src_trap_out, bus_error_out;
    logic [31:0] stall_cycles_out;

    always #5 clk_in = ~clk_in;

    msrv32_pipe_ctrl #(.MEM_TIMEOUT(16), .TRAP_FLUSH_CYC(2), .STALL_CNT_W(32)) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .rs1_addr_in      (rs1_addr_in),
        .rs2_addr_in      (rs2_addr_in),
        .rs_used_in       (rs_used_in),
        .rd_addr_reg_in   (rd_addr_reg_in),
        .rf_wr_en_reg_in  (rf_wr_en_reg_in),
        .load_reg_in      (load_reg_in),
        .mem_req_reg_in   (mem_req_reg_in),
        .dmem_ready_in    (dmem_ready_in),
        .branch_taken_in  (branch_taken_in),
        .trap_taken_in    (trap_taken_in),
        .pc_stall_out     (pc_stall_out),
        .reg1_stall_out   (reg1_stall_out),
        .reg2_stall_out   (reg2_stall_out),
        .reg1_flush_out   (reg1_flush_out),
        .reg2_flush_out   (reg2_flush_out),
        .pc_src_trap_out  (pc_src_trap_out),
        .bus_error_out    (bus_error_out),
        .stall_cycles_out (stall_cycles_out)
    );

    // expected bits: {pc_stall, reg1_stall, reg2_stall, reg1_flush, reg2_flush, pc_src_trap, bus_error}
    localparam logic [6:0] E_IDLE  = 7'b0000000;
    localparam logic [6:0] E_RST   = 7'b0001100;
    localparam logic [6:0] E_LUH   = 7'b1100100;
    localparam logic [6:0] E_MEM   = 7'b1110000;
    localparam logic [6:0] E_TRAP  = 7'b0001110;
    localparam logic [6:0] E_DRAIN = 7'b0001100;
    localparam logic [6:0] E_BERRD = 7'b0001101;
    localparam logic [6:0] E_BR    = 7'b0001000;
    localparam logic [6:0] E_PTRAP = 7'b0000010;

    typedef struct {
        string      name;
        logic       rst;
        reg_addr_t  rs1, rs2, rd;
        logic [1:0] used;
        logic       wr, ld, mreq, rdy, br, trap;
        logic [6:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [6:0]  sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] cnt_model = '0;

    function automatic vec_t mk(string name, logic rst, reg_addr_t rs1, reg_addr_t rs2,
                                logic [1:0] used, reg_addr_t rd, logic wr, logic ld,
                                logic mreq, logic rdy, logic br, logic trap, logic [6:0] exp);
        vec_t v;
        v.name = name; v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.used = used; v.rd = rd;
        v.wr = wr; v.ld = ld; v.mreq = mreq; v.rdy = rdy; v.br = br; v.trap = trap; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t idle(string name, logic [6:0] exp);
        return mk(name, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, exp);
    endfunction

    function automatic vec_t mem(string name, logic rdy, logic trap, logic [6:0] exp);
        return mk(name, 0, 0, 0, 2'b00, 0, 0, 0, 1, rdy, 0, trap, exp);
    endfunction

    initial begin
        logic [6:0] got, exp;

        // reset held three cycles, then released
        for (int i = 0; i < 3; i++) vecs.push_back(mk("reset_hold", 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, E_RST));
        vecs.push_back(idle("rst_release", E_IDLE));

        // load-use hazards and their non-hazard neighbours
        vecs.push_back(mk("luh_rs1", 0, 5, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, E_LUH));
        vecs.push_back(idle("luh_bubble_done", E_IDLE));
        vecs.push_back(mk("luh_rd0", 0, 0, 0, 2'b01, 0, 1, 1, 0, 0, 0, 0, E_IDLE));
        vecs.push_back(mk("luh_rs2", 0, 3, 7, 2'b10, 7, 1, 1, 0, 0, 0, 0, E_LUH));
        vecs.push_back(mk("rs2_unused", 0, 3, 7, 2'b01, 7, 1, 1, 0, 0, 0, 0, E_IDLE));
        vecs.push_back(mk("no_wr_en", 0, 9, 0, 2'b01, 9, 0, 1, 0, 0, 0, 0, E_IDLE));
        vecs.push_back(mk("not_load", 0, 9, 0, 2'b01, 9, 1, 0, 0, 0, 0, 0, E_IDLE));

        // dmem wait of four cycles
        for (int i = 0; i < 4; i++) vecs.push_back(mem("mem_wait4", 0, 0, E_MEM));
        vecs.push_back(mem("mem_ready", 1, 0, E_IDLE));
        vecs.push_back(idle("mem_no_berr", E_IDLE));

        // dmem timeout: 16 stalled cycles, trap redirect, bus error next cycle
        for (int i = 0; i < 16; i++) vecs.push_back(mem("timeout_wait", 0, 0, E_MEM));
        vecs.push_back(mem("timeout_fire", 0, 0, E_TRAP));
        vecs.push_back(idle("timeout_drain", E_BERRD));
        vecs.push_back(idle("timeout_back_run", E_IDLE));

        // branch coincident with load-use: only stage 1 flushed
        vecs.push_back(mk("branch_luh", 0, 5, 0, 2'b01, 5, 1, 1, 0, 0, 1, 0, E_BR));
        vecs.push_back(idle("branch_after", E_IDLE));

        // trap in RUN; trap during drain is ignored
        vecs.push_back(mk("trap_run", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, E_TRAP));
        vecs.push_back(mk("trap_drain_ign", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, E_DRAIN));
        vecs.push_back(idle("trap_back_run", E_IDLE));

        // trap during MEM_WAIT, deferred until ready
        vecs.push_back(mem("mw_trap_start", 0, 0, E_MEM));
        vecs.push_back(mem("mw_trap_pulse", 0, 1, E_MEM));
        vecs.push_back(mem("mw_trap_wait", 0, 0, E_MEM));
        vecs.push_back(mem("mw_trap_wait", 0, 0, E_MEM));
        vecs.push_back(mem("mw_trap_ready", 1, 0, E_PTRAP));
        vecs.push_back(mk("mw_drain0_trap", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, E_DRAIN));
        vecs.push_back(idle("mw_drain1", E_DRAIN));
        vecs.push_back(idle("mw_back_run", E_IDLE));

        // trap coincident with the stall-inducing RUN cycle is remembered
        vecs.push_back(mem("co_trap_stall", 0, 1, E_MEM));
        vecs.push_back(mem("co_trap_ready", 1, 0, E_PTRAP));
        vecs.push_back(idle("co_drain0", E_DRAIN));
        vecs.push_back(idle("co_drain1", E_DRAIN));
        vecs.push_back(idle("co_back_run", E_IDLE));

        // reset in MEM_WAIT discards the pending trap
        vecs.push_back(mem("rst_mw_start", 0, 0, E_MEM));
        vecs.push_back(mem("rst_mw_trap", 0, 1, E_MEM));
        vecs.push_back(mk("rst_mw_reset", 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, E_RST));
        vecs.push_back(mem("rst_mw_again", 0, 0, E_MEM));
        vecs.push_back(mem("rst_mw_ready", 1, 0, E_IDLE));
        vecs.push_back(idle("rst_mw_end", E_IDLE));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk_in);
            #1;
            reset_in        = vecs[i].rst;
            rs1_addr_in     = vecs[i].rs1;
            rs2_addr_in     = vecs[i].rs2;
            rs_used_in      = vecs[i].used;
            rd_addr_reg_in  = vecs[i].rd;
            rf_wr_en_reg_in = vecs[i].wr;
            load_reg_in     = vecs[i].ld;
            mem_req_reg_in  = vecs[i].mreq;
            dmem_ready_in   = vecs[i].rdy;
            branch_taken_in = vecs[i].br;
            trap_taken_in   = vecs[i].trap;
            sb.push_back(vecs[i].exp);

            @(negedge clk_in);
            got = {pc_stall_out, reg1_stall_out, reg2_stall_out, reg1_flush_out,
                   reg2_flush_out, pc_src_trap_out, bus_error_out};
            exp = sb.pop_front();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s (cycle %0d): outputs got %b expected %b", vecs[i].name, i, got, exp);
            end

            if (vecs[i].rst) cnt_model = '0;
            tests++;
            if (stall_cycles_out !== cnt_model) begin
                fails++;
                $display("FAIL %s stall_cycles (cycle %0d): got %0d expected %0d",
                         vecs[i].name, i, stall_cycles_out, cnt_model);
            end
            if (exp[6] && !vecs[i].rst) cnt_model = cnt_model + 32'd1;

            if (vecs[i].name == "rst_release") begin
                tests++;
                if (dut.state !== RUN) begin
                    fails++;
                    $display("FAIL rst_state: got %0d expected %0d", dut.state, RUN);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
